// File: rtl/layer_inter_1_2_pool_reader.sv
// Scans the layer-1/2 intermediate buffer through both RAM ports (rows r and r+1)
// and streams signed 2x2 max-pooled values to layer 2, then pulses done.
module layer_inter_1_2_pool_reader #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 16,
    parameter int FMAP_WIDTH  = 22,
    parameter int FMAP_HEIGHT = 22
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  layer_reset,
    output logic                  rden_a,
    output logic                  rden_b,
    output logic                  wren_a,
    output logic                  wren_b,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  pool_valid,
    output logic [ADDR_WIDTH-1:0] pool_index,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO       = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] WIDTH_A   = ADDR_WIDTH'(FMAP_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WRAP_STEP = ADDR_WIDTH'(FMAP_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(FMAP_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(FMAP_HEIGHT - 2);
    localparam logic [ADDR_WIDTH-1:0] POOL_LAST = ADDR_WIDTH'((FMAP_WIDTH / 2) * (FMAP_HEIGHT / 2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0]         addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]         addr_b_q, addr_b_d;
    logic                          rd_valid_q, rd_valid_d;
    logic                          col_odd_q, col_odd_d;
    logic signed [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic signed [DATA_WIDTH-1:0]  pool_out_q, pool_out_d;
    logic                          pool_valid_q, pool_valid_d;
    logic [ADDR_WIDTH-1:0]         pool_index_q, pool_index_d;
    logic                          done_q, done_d;

    logic                          rd_issue;
    logic signed [DATA_WIDTH-1:0]  qa_s, qb_s, col_max, win_max;

    assign qa_s    = q_a;
    assign qb_s    = q_b;
    assign col_max = (qa_s >= qb_s) ? qa_s : qb_s;
    assign win_max = (hold_q >= col_max) ? hold_q : col_max;

    assign rd_issue   = (state_q == S_READ) && enable;
    assign rden_a     = rd_issue;
    assign rden_b     = rd_issue;
    assign wren_a     = 1'b0;
    assign wren_b     = 1'b0;
    assign address_a  = addr_a_q;
    assign address_b  = addr_b_q;
    assign pool_out   = pool_out_q;
    assign pool_valid = pool_valid_q;
    assign pool_index = pool_index_q;
    assign done       = done_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        hold_d       = hold_q;
        pool_out_d   = pool_out_q;
        pool_valid_d = 1'b0;
        pool_index_d = pool_index_q;
        done_d       = 1'b0;
        rd_valid_d   = rd_issue;
        col_odd_d    = col_q[0];

        // Even column returns seed the window, odd column returns close it.
        if (pool_valid_q) pool_index_d = pool_index_q + ONE;
        if (rd_valid_q) begin
            if (!col_odd_q) begin
                hold_d = col_max;
            end else begin
                pool_out_d   = win_max;
                pool_valid_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                row_d    = '0;
                col_d    = '0;
                addr_a_d = '0;
                addr_b_d = WIDTH_A;
                if (enable) state_d = S_READ;
            end
            S_READ: begin
                if (rd_issue) begin
                    if (col_q == COL_LAST) begin
                        col_d    = '0;
                        row_d    = row_q + TWO;
                        addr_a_d = addr_a_q + WRAP_STEP;
                        addr_b_d = addr_b_q + WRAP_STEP;
                        if (row_q == ROW_LAST) state_d = S_DRAIN;
                    end else begin
                        col_d    = col_q + ONE;
                        addr_a_d = addr_a_q + ONE;
                        addr_b_d = addr_b_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (pool_valid_q && (pool_index_q == POOL_LAST)) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end
            end
            S_FINISH: begin
                // Parked until the controller clears us, so a lingering grant cannot rescan.
                state_d = S_FINISH;
            end
            default: state_d = S_IDLE;
        endcase

        if (layer_reset) begin
            state_d      = S_IDLE;
            row_d        = '0;
            col_d        = '0;
            addr_a_d     = '0;
            addr_b_d     = WIDTH_A;
            rd_valid_d   = 1'b0;
            col_odd_d    = 1'b0;
            hold_d       = '0;
            pool_out_d   = '0;
            pool_valid_d = 1'b0;
            pool_index_d = '0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            rd_valid_q   <= 1'b0;
            col_odd_q    <= 1'b0;
            hold_q       <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
            pool_index_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            rd_valid_q   <= rd_valid_d;
            col_odd_q    <= col_odd_d;
            hold_q       <= hold_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            pool_index_q <= pool_index_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_layer_inter_1_2_pool_reader.sv
// Bench for the pool reader on a 4x4 map: behavioural buffer model plus
// queued expectations for read addresses and pooled results.
module tb_layer_inter_1_2_pool_reader;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        layer_reset;
    logic        rden_a, rden_b, wren_a, wren_b;
    logic [8:0]  address_a, address_b;
    logic [15:0] q_a, q_b;
    logic [15:0] pool_out;
    logic        pool_valid;
    logic [8:0]  pool_index;
    logic        done;

    layer_inter_1_2_pool_reader #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (16),
        .FMAP_WIDTH (4),
        .FMAP_HEIGHT(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .layer_reset(layer_reset),
        .rden_a     (rden_a),
        .rden_b     (rden_b),
        .wren_a     (wren_a),
        .wren_b     (wren_b),
        .address_a  (address_a),
        .address_b  (address_b),
        .q_a        (q_a),
        .q_b        (q_b),
        .pool_out   (pool_out),
        .pool_valid (pool_valid),
        .pool_index (pool_index),
        .done       (done)
    );

    typedef struct {int a; int b;} rd_t;
    typedef struct {int idx; int val;} pl_t;
    typedef struct {
        bit neg;
        int pause_after;
        int pause_len;
        int exp [4];
    } vec_t;

    int   compares = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   reads_seen = 0;
    int   last_rd_cyc = 0;
    int   done_cyc = 0;
    int   done_cnt = 0;
    bit   mem_neg = 1'b0;
    rd_t  rd_q [$];
    pl_t  pool_q [$];
    rd_t  rd_exp [8];
    vec_t vecs [3];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [8:0] addr);
        int k;
        k = int'(addr);
        return mem_neg ? 16'(-k - 1) : 16'(k - 8);
    endfunction

    // Buffer model with one-cycle read latency
    always @(posedge clock) begin
        if (rden_a) q_a <= mem_word(address_a);
        if (rden_b) q_b <= mem_word(address_b);
    end

    task automatic check(input string name, input int got, input int exp);
        compares++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic monitor();
        rd_t e;
        pl_t p;
        forever begin
            @(negedge clock);
            check("wren_zero", int'({wren_a, wren_b}), 0);
            if (rden_a || rden_b) begin
                reads_seen++;
                last_rd_cyc = cyc;
                if (rd_q.size() == 0) begin
                    compares++;
                    errors++;
                    $display("FAIL unexpected_read: got a=%0d b=%0d, expected no read", address_a, address_b);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr_a", int'(address_a), e.a);
                    check("rd_addr_b", int'(address_b), e.b);
                    check("rden_pair", int'(rden_a), int'(rden_b));
                end
            end
            if (pool_valid) begin
                if (pool_q.size() == 0) begin
                    compares++;
                    errors++;
                    $display("FAIL unexpected_pool: got value %0d index %0d, expected no pool_valid",
                             $signed(pool_out), pool_index);
                end else begin
                    p = pool_q.pop_front();
                    check("pool_out", int'($signed(pool_out)), p.val);
                    check("pool_index", int'(pool_index), p.idx);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic wait_reads(input int n);
        int b;
        b = 0;
        while (reads_seen < n && b < 100) begin
            @(posedge clock); #1;
            b++;
        end
        check("wait_reads_reached", (reads_seen >= n) ? 1 : 0, 1);
    endtask

    task automatic load_queues(input vec_t v, input int n_pool);
        pl_t p;
        for (int i = 0; i < 8; i++) rd_q.push_back(rd_exp[i]);
        for (int i = 0; i < n_pool; i++) begin
            p.idx = i;
            p.val = v.exp[i];
            pool_q.push_back(p);
        end
    endtask

    task automatic do_layer_reset();
        @(posedge clock); #1;
        enable      = 1'b0;
        layer_reset = 1'b1;
        @(posedge clock); #1;
        layer_reset = 1'b0;
    endtask

    task automatic run_scan(input vec_t v);
        int done0;
        int b;
        mem_neg    = v.neg;
        load_queues(v, 4);
        reads_seen = 0;
        done0      = done_cnt;
        enable     = 1'b1;
        if (v.pause_after > 0) begin
            wait_reads(v.pause_after);
            enable = 1'b0;
            repeat (v.pause_len) begin
                @(negedge clock);
                check("pause_rden", int'(rden_a | rden_b), 0);
                check("pause_addr_a", int'(address_a), rd_exp[v.pause_after].a);
                check("pause_addr_b", int'(address_b), rd_exp[v.pause_after].b);
                @(posedge clock); #1;
            end
            enable = 1'b1;
        end
        b = 0;
        while (done_cnt == done0 && b < 100) begin
            @(posedge clock); #1;
            b++;
        end
        check("done_count", done_cnt - done0, 1);
        check("done_latency", done_cyc - last_rd_cyc, 3);
        check("reads_left", rd_q.size(), 0);
        check("pools_left", pool_q.size(), 0);
    endtask

    initial begin
        int r0, d0;
        for (int i = 0; i < 4; i++) begin
            rd_exp[i].a     = i;
            rd_exp[i].b     = i + 4;
            rd_exp[i + 4].a = i + 8;
            rd_exp[i + 4].b = i + 12;
        end
        vecs[0].neg = 1'b0; vecs[0].pause_after = 0; vecs[0].pause_len = 0;
        vecs[0].exp = '{-3, -1, 5, 7};
        vecs[1].neg = 1'b1; vecs[1].pause_after = 0; vecs[1].pause_len = 0;
        vecs[1].exp = '{-1, -3, -9, -11};
        vecs[2].neg = 1'b0; vecs[2].pause_after = 3; vecs[2].pause_len = 3;
        vecs[2].exp = '{-3, -1, 5, 7};

        reset       = 1'b1;
        enable      = 1'b0;
        layer_reset = 1'b0;
        fork
            monitor();
        join_none

        #1;
        check("rst_addr_a", int'(address_a), 0);
        check("rst_addr_b", int'(address_b), 0);
        check("rst_rden", int'(rden_a | rden_b), 0);
        check("rst_pool_valid", int'(pool_valid), 0);
        check("rst_done", int'(done), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Async reset in the middle of a scan
        mem_neg    = 1'b0;
        load_queues(vecs[0], 4);
        reads_seen = 0;
        enable     = 1'b1;
        wait_reads(3);
        #2;
        reset = 1'b1;
        #1;
        check("areset_rden", int'(rden_a | rden_b), 0);
        check("areset_addr_a", int'(address_a), 0);
        check("areset_addr_b", int'(address_b), 0);
        check("areset_pool_valid", int'(pool_valid), 0);
        check("areset_pool_out", int'(pool_out), 0);
        check("areset_pool_index", int'(pool_index), 0);
        check("areset_done", int'(done), 0);
        @(posedge clock); #1;
        enable = 1'b0;
        reset  = 1'b0;
        rd_q.delete();
        pool_q.delete();

        // Table of full scans: plain, negative data, paused
        for (int i = 0; i < 3; i++) begin
            run_scan(vecs[i]);
            do_layer_reset();
        end

        // layer_reset after 5 reads discards the rest of the scan
        mem_neg    = 1'b0;
        load_queues(vecs[0], 2);
        reads_seen = 0;
        d0         = done_cnt;
        enable     = 1'b1;
        wait_reads(5);
        enable      = 1'b0;
        layer_reset = 1'b1;
        @(posedge clock); #1;
        layer_reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("lr_no_done", done_cnt, d0);
        check("lr_pool_left", pool_q.size(), 0);
        check("lr_reads", reads_seen, 5);
        rd_q.delete();
        run_scan(vecs[0]);

        // Enable held through FINISH must not restart
        r0 = reads_seen;
        d0 = done_cnt;
        repeat (10) @(posedge clock);
        #1;
        check("finish_no_reads", reads_seen, r0);
        check("finish_done_once", done_cnt, d0);
        do_layer_reset();
        run_scan(vecs[0]);

        enable = 1'b0;
        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule

// File: doc/layer_inter_1_2_pool_reader.md
# layer_inter_1_2_pool_reader

Downstream consumer of the layer-1/layer-2 intermediate feature-map buffer. When granted the buffer by the inter-layer controller, it scans the stored FMAP_HEIGHT × FMAP_WIDTH map through both RAM ports and performs 2×2 signed max-pooling. It streams one pooled value per window to layer 2, then signals done back to the controller. Its RAM-side outputs feed the controller's layer_next address/read/write mux inputs.

## Interface
Parameters:
- ADDR_WIDTH, 9: buffer address width.
- DATA_WIDTH, 16: signed feature word width.
- FMAP_WIDTH, 22: map columns; must be even and ≥2.
- FMAP_HEIGHT, 22: map rows; must be even and ≥2; FMAP_WIDTH*FMAP_HEIGHT ≤ 2^ADDR_WIDTH.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears everything.
- enable  in  1  grant from controller (layer_next_enable).
- layer_reset  in  1  synchronous one-cycle clear from controller (layer_next_reset); dominates enable.
- rden_a, rden_b  out  1  buffer read enables.
- wren_a, wren_b  out  1  buffer write enables; constant 0.
- address_a, address_b  out  ADDR_WIDTH  port A reads row r, port B reads row r+1.
- q_a, q_b  in  DATA_WIDTH  buffer read data; 1-cycle read latency.
- pool_out  out  DATA_WIDTH  pooled value; signed.
- pool_valid  out  1  one-cycle strobe when pool_out is new.
- pool_index  out  ADDR_WIDTH  index of the pooled value, 0 … (FMAP_WIDTH/2)*(FMAP_HEIGHT/2)-1.
- done  out  1  one-cycle pulse after the last pooled value.

## Operation
- Reset values: state IDLE; row, col and pool counters 0; all outputs 0.
- State IDLE:
  - address registers hold 0 and FMAP_WIDTH.
  - enable=1 → READ.
- State READ:
  - rden_a = rden_b = enable (combinational with state==READ).
  - address_a = row*FMAP_WIDTH+col and address_b = address_a+FMAP_WIDTH, both from registers. Maintain them incrementally, with no multiplier.
  - For each issued read: col+1. At col=FMAP_WIDTH-1, col wraps to 0, row+=2, and both addresses advance by FMAP_WIDTH+1.
  - enable=0 pauses: reads are deasserted and counters hold. Reads already in flight still complete.
  - Issuing the read at (row=FMAP_HEIGHT-2, col=FMAP_WIDTH-1) → DRAIN.
- Pooling pipeline (runs in every state):
  - rd_valid and col parity are delayed one cycle alongside each issued read.
  - Returned data with an even column: hold <= max(q_a,q_b).
  - Returned data with an odd column: pool_out <= max(hold, max(q_a,q_b)), pool_valid=1 for one cycle.
  - pool_index starts at 0 and increments after each pool_valid.
  - Comparisons are signed two's-complement; equal values give that value.
- State DRAIN: enable is ignored. Wait for the final pool_valid, then → FINISH.
- State FINISH:
  - done=1 on the entry cycle only.
  - Held until layer_reset, so an enable still high after done never restarts a scan.
- layer_reset=1 in any state:
  - Next state IDLE; counters, hold and pipeline flags cleared; pool_valid and done 0.
  - In-flight data is discarded.
- Async reset mid-scan: immediate return to reset values.

## Timing
- Enable seen in IDLE at cycle t → READ at t+1. First rden at t+1 if enable is still 1.
- Read issued at cycle T → q at T+1 → pool_out/pool_valid registered, visible at T+2 for odd columns.
- Last read at T → final pool_valid at T+2 → done at T+3 → FINISH from T+3.
- Uninterrupted scan: FMAP_WIDTH*FMAP_HEIGHT/2 read cycles. One pool_valid every 2 cycles.
- wren_a, wren_b are 0 in every cycle.

## Test plan
Bench uses FMAP_WIDTH=4, FMAP_HEIGHT=4, and buffer word k = k-8 (signed).
- Async reset mid-READ → all outputs 0 and state IDLE in the same cycle. Then enable → scan restarts at address_a=0 and address_b=4.
- Full scan with enable held:
  - Reads (a,b) are (0,4),(1,5),(2,6),(3,7),(8,12),(9,13),(10,14),(11,15).
  - pool_valid ×4 with pool_out -3,-1,5,7 and pool_index 0..3.
  - done exactly 3 cycles after the last read.
- Negative data (buffer word k = -k-1) → pool_out -1,-3,-9,-11, checking the signed max.
- enable dropped for 3 cycles after the 3rd read:
  - rden low during the pause and addresses frozen at (3,7).
  - The in-flight 3rd read still returns.
  - Results are identical to the uninterrupted scan.
- layer_reset during READ after 5 reads → no further pool_valid and no done. The next scan produces the full 4 results from index 0.
- Enable held high through FINISH for 10 cycles → no rden and done pulses only once. layer_reset then enable → a second full scan.
